// File: rtl/nrf_spi_responder_if.sv
// Pin and local-fabric bundle for nrf_spi_responder. The master side is the SPI master plus the
// fabric logic that injects RX payloads and drains TX payloads.
interface nrf_spi_responder_if;
   logic       NRF_SCK;
   logic       NRF_CSN;
   logic       NRF_MOSI;
   logic       NRF_MISO;
   logic       NRF_IRQ;
   logic       rx_wr_en;
   logic [7:0] rx_wr_data;
   logic       rx_commit;
   logic       rx_full;
   logic       tx_rd_en;
   logic [7:0] tx_rd_data;
   logic       tx_avail;

   modport master (
      output NRF_SCK, NRF_CSN, NRF_MOSI, rx_wr_en, rx_wr_data, rx_commit, tx_rd_en,
      input  NRF_MISO, NRF_IRQ, rx_full, tx_rd_data, tx_avail
   );

   modport slave (
      input  NRF_SCK, NRF_CSN, NRF_MOSI, rx_wr_en, rx_wr_data, rx_commit, tx_rd_en,
      output NRF_MISO, NRF_IRQ, rx_full, tx_rd_data, tx_avail
   );
endinterface

// File: rtl/nrf_spi_responder.sv
// SPI mode-0 responder emulating the nRF24L01 command/register interface with local RX/TX buffers.
// Define NRF_SPI_RESPONDER_IRQ_EN to generate NRF_IRQ; otherwise NRF_IRQ is tied high.
module nrf_spi_responder #(
   parameter int unsigned PAYLOAD_BYTES = 32,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input logic                CLOCK_50,
   input logic                RESET,
   nrf_spi_responder_if.slave bus_io
);

   localparam int unsigned CW = $clog2(PAYLOAD_BYTES + 1);

   typedef enum logic [1:0] {StIdle, StCmd, StData, StIgnore} state_e;
   typedef enum logic [1:0] {CmdRReg, CmdWReg, CmdRRx, CmdWTx} cmd_e;

   logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
   logic                   sck_prev_q;
   logic                   sck_s, csn_s, mosi_s, sck_rise, sck_fall;

   state_e          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [6:0]      shift_in_q, shift_in_d;
   logic [7:0]      shift_out_q, shift_out_d;
   logic            miso_q, miso_d;
   cmd_e            cmd_q, cmd_d;
   logic [4:0]      addr_q, addr_d;
   logic [7:0]      reg_q [32];
   logic [7:0]      reg_d [32];
   logic            rx_dr_q, rx_dr_d, tx_ds_q, tx_ds_d;
   logic [7:0]      rx_buf_q [PAYLOAD_BYTES];
   logic [7:0]      rx_buf_d [PAYLOAD_BYTES];
   logic [CW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic            rx_full_q, rx_full_d, rx_read_q, rx_read_d;
   logic [7:0]      tx_buf_q [PAYLOAD_BYTES];
   logic [7:0]      tx_buf_d [PAYLOAD_BYTES];
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [7:0]      tx_rd_data_q, tx_rd_data_d;
   logic            tx_avail_q, tx_avail_d, tx_wrote_q, tx_wrote_d;

   logic [7:0] rx_byte, status, rd_cmd_data, rd_next_data, rx_buf_next, tx_buf_next, out_byte;
   logic [4:0] addr_inc;
   logic       is_rreg, is_wreg, is_rrx, is_wtx, spi_start, spi_end, byte_done;

   function automatic logic [7:0] reg_rst(int a);
      case (a)
         0:       return 8'h08;
         1:       return 8'h3F;
         2, 3, 4: return 8'h03;
         5:       return 8'h02;
         6:       return 8'h0E;
         default: return 8'h00;
      endcase
   endfunction

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         sck_sync_q  <= '0;
         csn_sync_q  <= '1;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus_io.NRF_SCK};
         csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], bus_io.NRF_CSN};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_io.NRF_MOSI};
         sck_prev_q  <= sck_s;
      end
   end

   assign sck_s     = sck_sync_q[SYNC_STAGES-1];
   assign csn_s     = csn_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise  = sck_s & ~sck_prev_q;
   assign sck_fall  = ~sck_s & sck_prev_q;
   // Level-based start/end also recovers a transfer whose CSN was already low at reset release.
   assign spi_start = ~csn_s & (state_q == StIdle);
   assign spi_end   = csn_s & (state_q != StIdle);
   assign byte_done = sck_rise & (bit_cnt_q == 3'd7) & ~csn_s & (state_q != StIdle);

   assign rx_byte  = {shift_in_q, mosi_s};
   assign status   = {1'b0, rx_dr_q, tx_ds_q, 1'b0, rx_full_q ? 3'b000 : 3'b111, tx_avail_q};
   assign is_rreg  = (rx_byte[7:5] == 3'b000);
   assign is_wreg  = (rx_byte[7:5] == 3'b001);
   assign is_rrx   = (rx_byte == 8'h61);
   assign is_wtx   = (rx_byte == 8'hA0) & ~tx_avail_q;
   assign addr_inc = addr_q + 5'd1;
   assign rd_cmd_data  = (rx_byte[4:0] == 5'd7) ? status : reg_q[rx_byte[4:0]];
   assign rd_next_data = (addr_inc == 5'd7) ? status : reg_q[addr_inc];

   always_comb begin
      rx_buf_next = '0;
      tx_buf_next = '0;
      for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
         if (i == int'(rx_rd_ptr_q) + 1) rx_buf_next = rx_buf_q[i];
         if (i == int'(tx_rd_ptr_q) + 1) tx_buf_next = tx_buf_q[i];
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (spi_start) state_d = StCmd;
      else if (spi_end) state_d = StIdle;
      else if (byte_done && state_q == StCmd)
         state_d = (is_rreg | is_wreg | is_rrx | is_wtx) ? StData : StIgnore;
   end

   always_comb begin
      bus_io.NRF_MISO = miso_q & (state_q != StIdle);
   end

   always_comb begin
      bit_cnt_d = bit_cnt_q;   shift_in_d = shift_in_q;   shift_out_d = shift_out_q;
      miso_d = miso_q;         cmd_d = cmd_q;             addr_d = addr_q;
      reg_d = reg_q;           rx_dr_d = rx_dr_q;         tx_ds_d = tx_ds_q;
      rx_buf_d = rx_buf_q;     rx_wr_ptr_d = rx_wr_ptr_q; rx_rd_ptr_d = rx_rd_ptr_q;
      rx_full_d = rx_full_q;   rx_read_d = rx_read_q;     tx_buf_d = tx_buf_q;
      tx_cnt_d = tx_cnt_q;     tx_rd_ptr_d = tx_rd_ptr_q; tx_rd_data_d = tx_rd_data_q;
      tx_avail_d = tx_avail_q; tx_wrote_d = tx_wrote_q;   out_byte = '0;

      if (bus_io.tx_rd_en && tx_avail_q) begin
         if (int'(tx_rd_ptr_q) + 1 >= int'(tx_cnt_q)) begin
            tx_avail_d = 1'b0;
         end else begin
            tx_rd_ptr_d  = tx_rd_ptr_q + CW'(1);
            tx_rd_data_d = tx_buf_next;
         end
      end

      if (spi_start) begin
         bit_cnt_d   = '0;
         shift_out_d = {status[6:0], 1'b0};
         miso_d      = status[7];
         rx_read_d   = 1'b0;
         tx_wrote_d  = 1'b0;
      end else if (spi_end) begin
         bit_cnt_d = '0;
         miso_d    = 1'b0;
         if (rx_read_q) rx_full_d = 1'b0;
         if (tx_wrote_q) begin
            tx_avail_d   = 1'b1;
            tx_ds_d      = 1'b1;
            tx_rd_ptr_d  = '0;
            tx_rd_data_d = tx_buf_q[0];
         end
      end else if (state_q != StIdle) begin
         if (sck_rise) begin
            shift_in_d = {shift_in_q[5:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               case (state_q)
                  StCmd: begin
                     if (is_rreg) begin
                        cmd_d = CmdRReg; addr_d = rx_byte[4:0]; out_byte = rd_cmd_data;
                     end else if (is_wreg) begin
                        cmd_d = CmdWReg; addr_d = rx_byte[4:0];
                     end else if (is_rrx) begin
                        cmd_d = CmdRRx; rx_rd_ptr_d = '0; out_byte = rx_buf_q[0];
                     end else if (is_wtx) begin
                        cmd_d = CmdWTx; tx_cnt_d = '0; tx_rd_ptr_d = '0;
                     end else if (rx_byte == 8'hE1) begin
                        tx_avail_d = 1'b0; tx_cnt_d = '0; tx_rd_ptr_d = '0;
                     end else if (rx_byte == 8'hE2) begin
                        rx_full_d = 1'b0; rx_wr_ptr_d = '0; rx_rd_ptr_d = '0;
                     end
                  end
                  StData: begin
                     unique case (cmd_q)
                        CmdRReg: begin
                           addr_d = addr_inc; out_byte = rd_next_data;
                        end
                        CmdWReg: begin
                           addr_d = addr_inc;
                           if (addr_q == 5'd7) begin
                              rx_dr_d = rx_dr_q & ~rx_byte[6];
                              tx_ds_d = tx_ds_q & ~rx_byte[5];
                           end else begin
                              reg_d[addr_q] = rx_byte;
                           end
                        end
                        CmdRRx: begin
                           rx_read_d = 1'b1;
                           out_byte  = rx_buf_next;
                           if (int'(rx_rd_ptr_q) < int'(PAYLOAD_BYTES))
                              rx_rd_ptr_d = rx_rd_ptr_q + CW'(1);
                        end
                        CmdWTx: begin
                           if (int'(tx_cnt_q) < int'(PAYLOAD_BYTES)) begin
                              for (int i = 0; i < int'(PAYLOAD_BYTES); i++)
                                 if (i == int'(tx_cnt_q)) tx_buf_d[i] = rx_byte;
                              tx_cnt_d   = tx_cnt_q + CW'(1);
                              tx_wrote_d = 1'b1;
                           end
                        end
                     endcase
                  end
                  default: ;
               endcase
               shift_out_d = out_byte;
            end
         end else if (sck_fall) begin
            miso_d      = shift_out_q[7];
            shift_out_d = {shift_out_q[6:0], 1'b0};
         end
      end

      // Local RX side follows the SPI side so a commit beats a same-cycle W1C of RX_DR.
      if (!rx_full_q) begin
         if (bus_io.rx_wr_en && int'(rx_wr_ptr_q) < int'(PAYLOAD_BYTES)) begin
            for (int i = 0; i < int'(PAYLOAD_BYTES); i++)
               if (i == int'(rx_wr_ptr_q)) rx_buf_d[i] = bus_io.rx_wr_data;
            rx_wr_ptr_d = rx_wr_ptr_q + CW'(1);
         end
         if (bus_io.rx_commit && rx_wr_ptr_q != '0) begin
            rx_full_d   = 1'b1;
            rx_dr_d     = 1'b1;
            rx_wr_ptr_d = '0;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         bit_cnt_q <= '0;   shift_in_q <= '0;   shift_out_q <= '0;  miso_q <= 1'b0;
         cmd_q <= CmdRReg;  addr_q <= '0;       rx_dr_q <= 1'b0;    tx_ds_q <= 1'b0;
         rx_wr_ptr_q <= '0; rx_rd_ptr_q <= '0;  rx_full_q <= 1'b0;  rx_read_q <= 1'b0;
         tx_cnt_q <= '0;    tx_rd_ptr_q <= '0;  tx_rd_data_q <= '0; tx_avail_q <= 1'b0;
         tx_wrote_q <= 1'b0;
         for (int i = 0; i < 32; i++) reg_q[i] <= reg_rst(i);
         for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
            rx_buf_q[i] <= '0;
            tx_buf_q[i] <= '0;
         end
      end else begin
         bit_cnt_q <= bit_cnt_d;     shift_in_q <= shift_in_d;   shift_out_q <= shift_out_d;
         miso_q <= miso_d;           cmd_q <= cmd_d;             addr_q <= addr_d;
         reg_q <= reg_d;             rx_dr_q <= rx_dr_d;         tx_ds_q <= tx_ds_d;
         rx_buf_q <= rx_buf_d;       rx_wr_ptr_q <= rx_wr_ptr_d; rx_rd_ptr_q <= rx_rd_ptr_d;
         rx_full_q <= rx_full_d;     rx_read_q <= rx_read_d;     tx_buf_q <= tx_buf_d;
         tx_cnt_q <= tx_cnt_d;       tx_rd_ptr_q <= tx_rd_ptr_d; tx_rd_data_q <= tx_rd_data_d;
         tx_avail_q <= tx_avail_d;   tx_wrote_q <= tx_wrote_d;
      end
   end

   assign bus_io.rx_full    = rx_full_q;
   assign bus_io.tx_avail   = tx_avail_q;
   assign bus_io.tx_rd_data = tx_rd_data_q;

`ifdef NRF_SPI_RESPONDER_IRQ_EN
   logic irq_q;
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) irq_q <= 1'b1;
      else       irq_q <= ~|({rx_dr_q, tx_ds_q, 1'b0} & ~reg_q[0][6:4]);
   end
   assign bus_io.NRF_IRQ = irq_q;
`else
   assign bus_io.NRF_IRQ = 1'b1;
`endif

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Directed bench for nrf_spi_responder: bit-banged SPI master plus local RX/TX fabric stimulus.
module tb_nrf_spi_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   nrf_spi_responder_if bus();

   nrf_spi_responder #(
      .PAYLOAD_BYTES(32),
      .SYNC_STAGES  (2)
   ) dut (
      .CLOCK_50(clk),
      .RESET   (rst),
      .bus_io  (bus)
   );

`ifdef NRF_SPI_RESPONDER_IRQ_EN
   localparam bit IrqEn = 1'b1;
`else
   localparam bit IrqEn = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] r0, r1, r2;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      bus.NRF_CSN = 1'b0;
      wait_clks(6);
   endtask

   task automatic cs_high();
      wait_clks(4);
      bus.NRF_CSN = 1'b1;
      wait_clks(8);
   endtask

   task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      miso = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         bus.NRF_MOSI = mosi[i];
         wait_clks(6);
         miso[i] = bus.NRF_MISO;
         bus.NRF_SCK = 1'b1;
         wait_clks(6);
         bus.NRF_SCK = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] mosi, output logic [7:0] miso);
      spi_bits(mosi, 8, miso);
   endtask

   task automatic reg_read(input logic [4:0] a, output logic [7:0] st, output logic [7:0] d);
      cs_low();
      spi_byte({3'b000, a}, st);
      spi_byte(8'hFF, d);
      cs_high();
   endtask

   task automatic reg_write(input logic [4:0] a, input logic [7:0] v);
      logic [7:0] dummy;
      cs_low();
      spi_byte({3'b001, a}, dummy);
      spi_byte(v, dummy);
      cs_high();
   endtask

   task automatic spi_cmd(input logic [7:0] c, output logic [7:0] st);
      cs_low();
      spi_byte(c, st);
      cs_high();
   endtask

   task automatic local_rx(input logic [7:0] d);
      bus.rx_wr_en = 1'b1;
      bus.rx_wr_data = d;
      wait_clks(1);
      bus.rx_wr_en = 1'b0;
   endtask

   task automatic pulse_commit();
      bus.rx_commit = 1'b1;
      wait_clks(1);
      bus.rx_commit = 1'b0;
      wait_clks(3);
   endtask

   task automatic pulse_pop();
      bus.tx_rd_en = 1'b1;
      wait_clks(1);
      bus.tx_rd_en = 1'b0;
      wait_clks(1);
   endtask

   initial begin
      bus.NRF_SCK = 1'b0;  bus.NRF_CSN = 1'b1;   bus.NRF_MOSI = 1'b0;
      bus.rx_wr_en = 1'b0; bus.rx_wr_data = '0;  bus.rx_commit = 1'b0;
      bus.tx_rd_en = 1'b0;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(3);

      check_eq("rst_miso", bus.NRF_MISO, 1'b0);
      check_eq("rst_irq", bus.NRF_IRQ, 1'b1);
      check_eq("rst_rx_full", bus.rx_full, 1'b0);
      check_eq("rst_tx_avail", bus.tx_avail, 1'b0);
      check_eq("rst_tx_rd_data", bus.tx_rd_data, 8'h00);

      reg_read(5'h05, r0, r1);
      check_eq("rd5_status", r0, 8'h0E);
      check_eq("rd5_data", r1, 8'h02);

      reg_write(5'h05, 8'h4C);
      reg_read(5'h05, r0, r1);
      check_eq("wr5_status", r0, 8'h0E);
      check_eq("wr5_data", r1, 8'h4C);

      cs_low();
      spi_byte(8'h1F, r0);
      spi_byte(8'hFF, r1);
      spi_byte(8'hFF, r2);
      cs_high();
      check_eq("wrap_reg1f", r1, 8'h00);
      check_eq("wrap_reg00", r2, 8'h08);

      local_rx(8'hAA);
      local_rx(8'h55);
      pulse_commit();
      check_eq("rx_full_set", bus.rx_full, 1'b1);
      check_eq("irq_rx_dr", bus.NRF_IRQ, IrqEn ? 1'b0 : 1'b1);

      cs_low();
      spi_byte(8'h61, r0);
      spi_byte(8'hFF, r1);
      spi_byte(8'hFF, r2);
      cs_high();
      check_eq("rrx_status", r0, 8'h40);
      check_eq("rrx_byte0", r1, 8'hAA);
      check_eq("rrx_byte1", r2, 8'h55);
      check_eq("rrx_rx_full_clr", bus.rx_full, 1'b0);
      check_eq("irq_after_read", bus.NRF_IRQ, IrqEn ? 1'b0 : 1'b1);

      reg_write(5'h07, 8'h40);
      wait_clks(3);
      check_eq("irq_rx_dr_clr", bus.NRF_IRQ, 1'b1);
      spi_cmd(8'hFF, r0);
      check_eq("nop_status_clr", r0, 8'h0E);

      cs_low();
      spi_byte(8'hA0, r0);
      spi_byte(8'h11, r0);
      spi_byte(8'h22, r0);
      cs_high();
      check_eq("wtx_avail", bus.tx_avail, 1'b1);
      check_eq("wtx_rd_data0", bus.tx_rd_data, 8'h11);
      check_eq("irq_tx_ds", bus.NRF_IRQ, IrqEn ? 1'b0 : 1'b1);
      spi_cmd(8'hFF, r0);
      check_eq("wtx_status", r0, 8'h2F);

      cs_low();
      spi_byte(8'hA0, r0);
      spi_byte(8'h99, r0);
      cs_high();
      check_eq("wtx_busy_ignored", bus.tx_rd_data, 8'h11);

      pulse_pop();
      check_eq("pop1_data", bus.tx_rd_data, 8'h22);
      check_eq("pop1_avail", bus.tx_avail, 1'b1);
      pulse_pop();
      check_eq("pop2_avail", bus.tx_avail, 1'b0);
      pulse_pop();
      check_eq("pop_empty_hold", bus.tx_rd_data, 8'h22);

      reg_write(5'h07, 8'h20);
      spi_cmd(8'hFF, r0);
      check_eq("tx_ds_clr_status", r0, 8'h0E);

      local_rx(8'h33);
      pulse_commit();
      check_eq("rx_full_again", bus.rx_full, 1'b1);
      spi_cmd(8'hE2, r0);
      check_eq("flush_rx_status", r0, 8'h40);
      check_eq("flush_rx_full", bus.rx_full, 1'b0);

      cs_low();
      spi_byte(8'h23, r0);
      spi_bits(8'hFF, 4, r1);
      bus.NRF_CSN = 1'b1;
      wait_clks(8);
      check_eq("partial_idle_miso", bus.NRF_MISO, 1'b0);
      reg_read(5'h03, r0, r1);
      check_eq("partial_status", r0, 8'h4E);
      check_eq("partial_reg3", r1, 8'h03);

      cs_low();
      spi_byte(8'h05, r0);
      spi_bits(8'hFF, 3, r1);
      rst = 1'b1;
      wait_clks(2);
      check_eq("mid_rst_miso", bus.NRF_MISO, 1'b0);
      bus.NRF_CSN = 1'b1;
      bus.NRF_SCK = 1'b0;
      wait_clks(2);
      rst = 1'b0;
      wait_clks(4);
      reg_read(5'h05, r0, r1);
      check_eq("post_rst_status", r0, 8'h0E);
      check_eq("post_rst_reg5", r1, 8'h02);
      check_eq("post_rst_irq", bus.NRF_IRQ, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
